// File: rtl/wb_ram_slave.sv
// Wishbone responder backed by a word-organised, byte-writable on-chip RAM.
// One request is captured, held for WAIT_CYCLES wait states, then answered
// with a single-cycle ack (in range) or err (out of range) pulse.
module wb_ram_slave #(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter int unsigned TAGSIZE     = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               wb_cyc,
    input  logic               wb_stb,
    input  logic               wb_we,
    input  logic [31:0]        wb_adr,
    input  logic [3:0]         wb_sel,
    input  logic [31:0]        wb_dat_ms,
    input  logic [TAGSIZE-1:0] wb_tgd_ms,
    input  logic [TAGSIZE-1:0] wb_tga,
    input  logic [TAGSIZE-1:0] wb_tgc,
    input  logic               wb_lock,
    output logic [31:0]        wb_dat_sm,
    output logic [TAGSIZE-1:0] wb_tgd_sm,
    output logic               wb_ack,
    output logic               wb_err,
    output logic               wb_rty
);

    localparam int unsigned CW    = ($clog2(WAIT_CYCLES + 1) > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] LIMIT = 32'(4 * DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic               we_q;
    logic [31:0]        adr_q;
    logic [3:0]         sel_q;
    logic [31:0]        dat_q;
    logic [TAGSIZE-1:0] tgd_q;
    logic [CW-1:0]      cnt_q;

    logic               capture;
    logic               access;
    logic               in_range;
    logic [AW-1:0]      word_idx;

    logic [31:0]        mem [DEPTH];

    // Tags other than the data tag and the lock are not used by this responder.
    logic unused_inputs;
    assign unused_inputs = ^{wb_tga, wb_tgc, wb_lock};

    assign wb_rty   = 1'b0;
    assign in_range = (adr_q < LIMIT);
    assign word_idx = adr_q[AW+1:2];

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; an abort (cyc low) in WAIT wins over a due access.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        access  = 1'b0;
        case (state_q)
            IDLE: begin
                if (wb_cyc && wb_stb) begin
                    capture = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (!wb_cyc) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    access  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request register and wait counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            we_q  <= 1'b0;
            adr_q <= '0;
            sel_q <= '0;
            dat_q <= '0;
            tgd_q <= '0;
            cnt_q <= '0;
        end else if (capture) begin
            we_q  <= wb_we;
            adr_q <= wb_adr;
            sel_q <= wb_sel;
            dat_q <= wb_dat_ms;
            tgd_q <= wb_tgd_ms;
            cnt_q <= CW'(WAIT_CYCLES);
        end else if (state_q == WAIT && cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // Response registers: loaded only on the access edge, so they are zero
    // in every cycle other than RESP.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wb_ack    <= 1'b0;
            wb_err    <= 1'b0;
            wb_dat_sm <= '0;
            wb_tgd_sm <= '0;
        end else begin
            wb_ack    <= 1'b0;
            wb_err    <= 1'b0;
            wb_dat_sm <= '0;
            wb_tgd_sm <= '0;
            if (access) begin
                wb_ack    <= in_range;
                wb_err    <= ~in_range;
                wb_tgd_sm <= tgd_q;
                if (!we_q && in_range) begin
                    wb_dat_sm <= mem[word_idx];
                end
            end
        end
    end

    // Byte-lane memory write; contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (access && we_q && in_range) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (sel_q[i]) begin
                    mem[word_idx][8*i +: 8] <= dat_q[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_ram_slave.sv
// Directed bench for wb_ram_slave: a zero-wait and a three-wait instance,
// both with a 16-word memory (legal byte offsets 0x00..0x3F).
module tb_wb_ram_slave;

    localparam int unsigned DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        cyc0, stb0, cyc3, stb3;
    logic        we;
    logic [31:0] adr, dat_ms;
    logic [3:0]  sel;
    logic [1:0]  tgd, tga, tgc;
    logic        lock;

    logic [31:0] dat0, dat3;
    logic [1:0]  tgd0, tgd3;
    logic        ack0, err0, rty0, ack3, err3, rty3;

    logic        cur3;
    logic        c_ack, c_err;
    logic [31:0] c_dat;
    logic [1:0]  c_tgd;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign c_ack = cur3 ? ack3 : ack0;
    assign c_err = cur3 ? err3 : err0;
    assign c_dat = cur3 ? dat3 : dat0;
    assign c_tgd = cur3 ? tgd3 : tgd0;

    wb_ram_slave #(.DEPTH(DEPTH), .WAIT_CYCLES(0), .TAGSIZE(2)) dut0 (
        .clk_i(clk), .rst_i(rst_i), .wb_cyc(cyc0), .wb_stb(stb0), .wb_we(we),
        .wb_adr(adr), .wb_sel(sel), .wb_dat_ms(dat_ms), .wb_tgd_ms(tgd),
        .wb_tga(tga), .wb_tgc(tgc), .wb_lock(lock), .wb_dat_sm(dat0),
        .wb_tgd_sm(tgd0), .wb_ack(ack0), .wb_err(err0), .wb_rty(rty0)
    );

    wb_ram_slave #(.DEPTH(DEPTH), .WAIT_CYCLES(3), .TAGSIZE(2)) dut3 (
        .clk_i(clk), .rst_i(rst_i), .wb_cyc(cyc3), .wb_stb(stb3), .wb_we(we),
        .wb_adr(adr), .wb_sel(sel), .wb_dat_ms(dat_ms), .wb_tgd_ms(tgd),
        .wb_tga(tga), .wb_tgc(tgc), .wb_lock(lock), .wb_dat_sm(dat3),
        .wb_tgd_sm(tgd3), .wb_ack(ack3), .wb_err(err3), .wb_rty(rty3)
    );

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic [1:0]  tgd;
        logic        exp_ack;
        logic        exp_err;
        logic        chk_dat;
        logic [31:0] exp_dat;
    } vec_t;

    vec_t vt [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic set_req(input logic d3, input logic on);
        if (d3) begin
            cyc3 = on;
            stb3 = on;
        end else begin
            cyc0 = on;
            stb0 = on;
        end
    endtask

    // One complete transfer: request presented before edge N, held until the
    // response is seen, then withdrawn. lat counts falling edges after edge N.
    task automatic xfer(input logic d3, input logic w, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] dm, input logic [1:0] t,
                        output logic g_ack, output logic g_err, output logic [31:0] g_dat,
                        output logic [1:0] g_tgd, output int lat, output logic quiet,
                        output logic one_wide);
        cur3 = d3;
        @(posedge clk); #1;
        we = w; adr = a; sel = s; dat_ms = dm; tgd = t;
        set_req(d3, 1'b1);
        @(posedge clk);
        lat = 0; quiet = 1'b1;
        g_ack = 1'b0; g_err = 1'b0; g_dat = '0; g_tgd = '0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (c_ack || c_err) begin
                g_ack = c_ack; g_err = c_err; g_dat = c_dat; g_tgd = c_tgd;
                lat = k;
                break;
            end
            if (c_dat != '0 || c_tgd != '0) quiet = 1'b0;
        end
        @(posedge clk); #1;
        set_req(d3, 1'b0);
        @(negedge clk);
        one_wide = !(c_ack || c_err) && (c_dat == '0);
    endtask

    logic        g_ack, g_err, quiet, one_wide;
    logic [31:0] g_dat;
    logic [1:0]  g_tgd;
    int          lat;
    int          resp_cnt;

    initial begin
        rst_i = 1'b1;
        {cyc0, stb0, cyc3, stb3} = '0;
        we = 1'b0; adr = '0; sel = '0; dat_ms = '0; tgd = '0;
        tga = 2'b01; tgc = 2'b10; lock = 1'b0; cur3 = 1'b0;

        vt[0]  = '{1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 2'd1, 1'b1, 1'b0, 1'b0, 32'h0};
        vt[1]  = '{1'b0, 32'h10, 4'hF, 32'h0,        2'd2, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF};
        vt[2]  = '{1'b1, 32'h20, 4'hF, 32'h11223344, 2'd0, 1'b1, 1'b0, 1'b0, 32'h0};
        vt[3]  = '{1'b1, 32'h20, 4'h5, 32'hAABBCCDD, 2'd3, 1'b1, 1'b0, 1'b0, 32'h0};
        vt[4]  = '{1'b0, 32'h20, 4'hF, 32'h0,        2'd1, 1'b1, 1'b0, 1'b1, 32'h11BB33DD};
        vt[5]  = '{1'b1, 32'h20, 4'h0, 32'hFFFFFFFF, 2'd2, 1'b1, 1'b0, 1'b0, 32'h0};
        vt[6]  = '{1'b0, 32'h20, 4'hF, 32'h0,        2'd3, 1'b1, 1'b0, 1'b1, 32'h11BB33DD};
        vt[7]  = '{1'b1, 32'h00, 4'hF, 32'hCAFEF00D, 2'd0, 1'b1, 1'b0, 1'b0, 32'h0};
        vt[8]  = '{1'b1, 32'h3C, 4'hF, 32'h01020304, 2'd1, 1'b1, 1'b0, 1'b0, 32'h0};
        vt[9]  = '{1'b1, 32'h40, 4'hF, 32'h5A5A5A5A, 2'd2, 1'b0, 1'b1, 1'b0, 32'h0};
        vt[10] = '{1'b0, 32'h00, 4'hF, 32'h0,        2'd3, 1'b1, 1'b0, 1'b1, 32'hCAFEF00D};
        vt[11] = '{1'b0, 32'h3C, 4'hF, 32'h0,        2'd0, 1'b1, 1'b0, 1'b1, 32'h01020304};
        vt[12] = '{1'b0, 32'h40, 4'hF, 32'h0,        2'd1, 1'b0, 1'b1, 1'b1, 32'h0};
        vt[13] = '{1'b0, 32'h3F, 4'hF, 32'h0,        2'd2, 1'b1, 1'b0, 1'b1, 32'h01020304};
        vt[14] = '{1'b0, 32'hFFFFFFFC, 4'hF, 32'h0,  2'd3, 1'b0, 1'b1, 1'b1, 32'h0};
        vt[15] = '{1'b1, 32'h12, 4'hC, 32'h99880000, 2'd0, 1'b1, 1'b0, 1'b0, 32'h0};
        vt[16] = '{1'b0, 32'h10, 4'hF, 32'h0,        2'd1, 1'b1, 1'b0, 1'b1, 32'h9988BEEF};

        // Reset values on both instances.
        #2;
        check("rst_outs0", {dat0, 28'(0), tgd0, ack0, err0, rty0}, '0);
        check("rst_outs3", {dat3, 28'(0), tgd3, ack3, err3, rty3}, '0);
        @(posedge clk); @(posedge clk); #1;
        rst_i = 1'b0;

        // Zero-wait instance, table driven.
        for (int i = 0; i < 17; i++) begin
            xfer(1'b0, vt[i].we, vt[i].adr, vt[i].sel, vt[i].dat, vt[i].tgd,
                 g_ack, g_err, g_dat, g_tgd, lat, quiet, one_wide);
            check($sformatf("v%0d_ack", i), 32'(g_ack), 32'(vt[i].exp_ack));
            check($sformatf("v%0d_err", i), 32'(g_err), 32'(vt[i].exp_err));
            check($sformatf("v%0d_tgd", i), 32'(g_tgd), 32'(vt[i].tgd));
            check($sformatf("v%0d_lat", i), 32'(lat), 32'd2);
            check($sformatf("v%0d_quiet", i), 32'(quiet), 32'd1);
            check($sformatf("v%0d_onewide", i), 32'(one_wide), 32'd1);
            if (vt[i].chk_dat) check($sformatf("v%0d_dat", i), g_dat, vt[i].exp_dat);
        end

        // Back-to-back: stb held high; one ack per three cycles.
        cur3 = 1'b0;
        @(posedge clk); #1;
        we = 1'b0; adr = 32'h20; sel = 4'hF; tgd = 2'd2;
        set_req(1'b0, 1'b1);
        @(posedge clk);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            check($sformatf("b2b_ack_c%0d", k), 32'(ack0), 32'((k % 3) == 2));
            if (k == 12) set_req(1'b0, 1'b0);
        end
        repeat (3) @(posedge clk);

        // Reset during RESP clears the pulse immediately.
        @(posedge clk); #1;
        we = 1'b0; adr = 32'h10; tgd = 2'd3;
        set_req(1'b0, 1'b1);
        @(posedge clk);
        @(posedge clk); #1;
        check("rresp_ack_before", 32'(ack0), 32'd1);
        check("rresp_dat_before", dat0, 32'h9988BEEF);
        rst_i = 1'b1;
        set_req(1'b0, 1'b0);
        #1;
        check("rresp_ack_after", 32'(ack0), 32'd0);
        check("rresp_dat_after", dat0, 32'h0);
        @(posedge clk); #1;
        rst_i = 1'b0;

        // Three-wait instance: write then read with latency check.
        xfer(1'b1, 1'b1, 32'h4, 4'hF, 32'h0BADCAFE, 2'd1, g_ack, g_err, g_dat, g_tgd, lat, quiet, one_wide);
        check("w3_ack", 32'(g_ack), 32'd1);
        check("w3_lat", 32'(lat), 32'd5);
        xfer(1'b1, 1'b0, 32'h4, 4'hF, 32'h0, 2'd2, g_ack, g_err, g_dat, g_tgd, lat, quiet, one_wide);
        check("r3_ack", 32'(g_ack), 32'd1);
        check("r3_lat", 32'(lat), 32'd5);
        check("r3_dat", g_dat, 32'h0BADCAFE);
        check("r3_tgd", 32'(g_tgd), 32'd2);
        check("r3_quiet", 32'(quiet), 32'd1);
        check("r3_onewide", 32'(one_wide), 32'd1);
        xfer(1'b1, 1'b1, 32'h8, 4'hF, 32'h12345678, 2'd0, g_ack, g_err, g_dat, g_tgd, lat, quiet, one_wide);
        check("w3b_ack", 32'(g_ack), 32'd1);

        // Abort: cyc dropped one cycle after the request edge.
        cur3 = 1'b1;
        @(posedge clk); #1;
        we = 1'b1; adr = 32'h8; sel = 4'hF; dat_ms = 32'hFFFFFFFF; tgd = 2'd3;
        set_req(1'b1, 1'b1);
        @(posedge clk);
        @(posedge clk); #1;
        set_req(1'b1, 1'b0);
        resp_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (ack3 || err3) resp_cnt++;
        end
        check("abort_noresp", 32'(resp_cnt), 32'd0);
        xfer(1'b1, 1'b0, 32'h8, 4'hF, 32'h0, 2'd1, g_ack, g_err, g_dat, g_tgd, lat, quiet, one_wide);
        check("abort_readback", g_dat, 32'h12345678);

        // Reset during WAIT discards the pending write.
        cur3 = 1'b1;
        @(posedge clk); #1;
        we = 1'b1; adr = 32'h8; sel = 4'hF; dat_ms = 32'hAAAAAAAA; tgd = 2'd2;
        set_req(1'b1, 1'b1);
        @(posedge clk);
        @(posedge clk); #1;
        rst_i = 1'b1;
        set_req(1'b1, 1'b0);
        #1;
        check("rwait_outs", {dat3, 28'(0), tgd3, ack3, err3, rty3}, '0);
        @(posedge clk); @(posedge clk); #1;
        rst_i = 1'b0;
        resp_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (ack3 || err3) resp_cnt++;
        end
        check("rwait_noresp", 32'(resp_cnt), 32'd0);
        xfer(1'b1, 1'b0, 32'h8, 4'hF, 32'h0, 2'd0, g_ack, g_err, g_dat, g_tgd, lat, quiet, one_wide);
        check("rwait_readback", g_dat, 32'h12345678);
        check("rwait_rd_lat", 32'(lat), 32'd5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard stop if the sequence above ever wedges.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/wb_ram_slave.md
# wb_ram_slave

Wishbone responder that terminates one port of the wishbone crossbar with a word-organised, byte-writable on-chip memory. It accepts classic single-cycle-request transfers and answers each with exactly one `wb_ack` or `wb_err` pulse after a programmable number of wait states. Because the crossbar has already subtracted the slave start address, `wb_adr` is a byte offset from 0.

## Interface
- `DEPTH`, 1024: memory size in 32-bit words; legal byte offsets are 0 .. 4*DEPTH-1.
- `WAIT_CYCLES`, 0: extra wait states between request capture and response, 0..15.
- `TAGSIZE`, 2: width of all tag signals.

Ports:
- `clk_i`  in  1  clock
- `rst_i`  in  1  reset, asynchronous, active-high
- `wb_cyc`  in  1  cycle in progress
- `wb_stb`  in  1  strobe; a request is `wb_cyc & wb_stb`
- `wb_we`  in  1  1 = write, 0 = read
- `wb_adr`  in  32  byte offset
- `wb_sel`  in  4  byte lanes; bit n selects `dat[8n+7:8n]`
- `wb_dat_ms`  in  32  write data
- `wb_tgd_ms`, `wb_tga`, `wb_tgc`  in  TAGSIZE  data, address and cycle tags; only `wb_tgd_ms` is used
- `wb_lock`  in  1  ignored; single responder, no arbitration here
- `wb_dat_sm`  out  32  read data
- `wb_tgd_sm`  out  TAGSIZE  response data tag
- `wb_ack`  out  1  normal termination
- `wb_err`  out  1  error termination
- `wb_rty`  out  1  retry; tied to 0

## Operation
- FSM states: IDLE, WAIT, RESP. Reset state is IDLE.
- **IDLE:** on a clock edge with `wb_cyc & wb_stb`, the block captures `wb_we`, `wb_adr`, `wb_sel`, `wb_dat_ms` and `wb_tgd_ms` into a request register.
  - It loads the wait counter with `WAIT_CYCLES`, with counter width `$clog2(WAIT_CYCLES+1)`, minimum 1.
  - Next state is WAIT.
- **WAIT:** the counter decrements each cycle.
  - When it reaches 0, or immediately if `WAIT_CYCLES`=0, the block performs the access and goes to RESP on that edge.
  - **Word index and range check:** word index = `adr_q[31:2]`; `adr_q[1:0]` is ignored. The request is out-of-range if `adr_q >= 4*DEPTH`, compared in 32-bit arithmetic.
  - **Write, in range:** on that edge, memory bytes with `sel_q[n]`=1 take `dat_q` byte n. Other bytes are unchanged; `sel_q`=0 writes nothing but still acks.
  - **Read, in range:** on that edge, `wb_dat_sm` is registered from the memory word.
  - **Out-of-range:** the block asserts `wb_err` instead of `wb_ack`. There is no memory write, and `wb_dat_sm` = 0.
  - `wb_tgd_sm` is registered from `tgd_q` on the same edge.
- **RESP:** `wb_ack` or `wb_err` is high for exactly this one cycle.
  - `wb_stb` is still high from the old request during RESP; it is ignored, not treated as a new request.
  - Next state is IDLE.
- **Abort:** if `wb_cyc`=0 at any edge while in WAIT, the FSM returns to IDLE. No write is performed and no response is given.
  - A `wb_cyc` drop during RESP has no effect; the pulse completes.
- Outside RESP, `wb_dat_sm`, `wb_tgd_sm`, `wb_ack` and `wb_err` are 0.
- `wb_ack` and `wb_err` are never high together.
- Memory contents are not reset and are retained across `rst_i`.

## Timing
- **Reset values:** `wb_ack`=0, `wb_err`=0, `wb_rty`=0, `wb_dat_sm`=0, `wb_tgd_sm`=0, FSM=IDLE, counter=0, request register=0.
- **Reset mid-operation:** asynchronous clear to the values above. Any pending write is discarded and no response is issued.
- **Latency:** request sampled at edge N; response visible in the cycle after edge N+1+`WAIT_CYCLES`.
  - With `WAIT_CYCLES`=0, the ack is high in the second cycle after the request cycle.
- **Throughput:** one transfer per `WAIT_CYCLES`+3 cycles.
  - A new request is accepted no earlier than the first IDLE cycle after RESP.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- **Reset values, then basic write/read:** after reset all outputs are 0. With `WAIT_CYCLES`=0, write 0xDEADBEEF to offset 0x10 with `sel`=4'hF, then read 0x10. Required: each ack is one cycle wide at N+2, and the read returns 0xDEADBEEF with `wb_tgd_sm` equal to the request's `wb_tgd_ms`.
- **Byte lanes:** word 0x20 = 0x11223344, then write 0xAABBCCDD with `sel`=4'b0101. Required: read returns 0x11BB33DD; `sel`=0 write acks and leaves the word unchanged.
- **Wait states:** `WAIT_CYCLES`=3, read offset 0x4. Required: ack appears exactly 4 cycles after the request edge, and `wb_dat_sm` is 0 in every other cycle.
- **Out-of-range:** `DEPTH`=16, write 0x5A5A5A5A to offset 0x40, then read offset 0x3C. Required: the write gives `wb_err`=1, `wb_ack`=0 and no memory change; the 0x3C read acks normally.
- **Abort:** `WAIT_CYCLES`=3, write to 0x8, then drop `wb_cyc` one cycle after the request. Required: no ack or err is ever issued, and a later read of 0x8 returns the old value.
- **Reset mid-operation and back-to-back stb:**
  - Assert `rst_i` during WAIT. Required: outputs clear immediately, no response, memory contents intact.
  - Hold `stb` high across RESP. Required: exactly one ack per request, with the next accepted only from IDLE.
